// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Consumers: ysyx_22050612_ifu_fetch, ysyx_22050612_pc_reg.
package ysyx_22050612_ifu_pkg;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t S_REQ  = 2'd0;
  localparam ifu_state_t S_WAIT = 2'd1;
  localparam ifu_state_t S_HOLD = 2'd2;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

  function automatic logic [31:0] pick_word(
    input logic        hi,
    input logic [63:0] dw
  );
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050612_pc_reg.sv
// PC register: sync reset, redirect mux, +4 incrementer.
// Redirect targets are forced to 4-byte alignment.
module ysyx_22050612_pc_reg
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~XLEN'(3);
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit top (ysyx_22050612_ifu_fetch).
// Optional: YSYX_22050612_IFU_EBREAK_HALT_EN parks the unit on ebreak.
module ysyx_22050612_ifu_fetch
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [63:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            halt
);

  ifu_state_t      state;
  logic            drop;
  logic [XLEN-1:0] pc;
  logic            halt_q;
  logic            parked;
  logic            rsp_ok;
  logic [31:0]     rsp_word;

  assign imem_req_valid = !rst && (state == S_REQ);
  assign imem_req_addr  = {pc[XLEN-1:3], 3'b000};
  assign inst_valid     = !rst && (state == S_HOLD) && !parked;
  assign halt           = halt_q;

  assign rsp_word = pick_word(pc[2], imem_rsp_data);
  // A same-cycle redirect makes the arriving response stale.
  assign rsp_ok = (state == S_WAIT) && imem_rsp_valid
               && !drop && !redirect_valid;

  ysyx_22050612_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (inst_valid && inst_ready),
    .pc             (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      drop    <= 1'b0;
      inst    <= INST_NOP;
      inst_pc <= '0;
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
            drop  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop <= 1'b0;
            if (rsp_ok) begin
              state   <= S_HOLD;
              inst    <= rsp_word;
              inst_pc <= pc;
            end else begin
              state <= S_REQ;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state <= halt_q ? S_HOLD : S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef YSYX_22050612_IFU_EBREAK_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      parked <= 1'b0;
    end else begin
      if (rsp_ok && (rsp_word == INST_EBREAK)) begin
        halt_q <= 1'b1;
      end
      if ((state == S_HOLD) && halt_q
          && (redirect_valid || inst_ready)) begin
        parked <= 1'b1;
      end
    end
  end
`else
  assign halt_q = 1'b0;
  assign parked = 1'b0;
`endif

endmodule
